// File: rtl/mips_pkg.sv
// Shared constants and state type for the write-back end of the operand path.
// Imported by wb_dest_select and register_writeback.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam logic [4:0] REG_T0 = 5'd8;
   localparam logic [4:0] REG_T7 = 5'd15;
   localparam logic [4:0] REG_S0 = 5'd16;
   localparam logic [4:0] REG_S7 = 5'd23;

   typedef enum logic {
      WB_IDLE,
      WB_WAIT_MEM
   } wb_state_t;

endpackage

// File: rtl/wb_dest_select.sv
// Destination decode: rd for R-type, rt otherwise; maps 8..23 onto file
// index 0..15 (t0..t7 then s0..s7).
module wb_dest_select
   import mips_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [4:0]  dest,
   output logic [3:0]  file_idx,
   output logic        dest_ok
);

   logic unused_fields;

   assign unused_fields = ^{instruction[25:21], instruction[10:0]};

   always_comb begin
      dest = instruction[20:16];
      if (instruction[31:26] == OP_RTYPE) begin
         dest = instruction[15:11];
      end
      dest_ok  = (dest >= REG_T0) && (dest <= REG_S7);
      file_idx = 4'(dest - REG_T0);
   end

endmodule

// File: rtl/register_writeback.sv
// Architectural s0..s7/t0..t7 file with ALU/load write-back and a load-wait FSM.
// Optional macro WB_BYPASS_EN forwards the value being written onto the outputs.
module register_writeback
   import mips_pkg::*;
#(
   parameter int                 DATA_W      = 32,
   parameter int                 MEM_TIMEOUT = 15,
   parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              RegW,
   input  logic              MemToReg,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdata_valid,
   output logic              wb_ignored,
   output logic              wb_timeout,
   output logic [DATA_W-1:0] s0,
   output logic [DATA_W-1:0] s1,
   output logic [DATA_W-1:0] s2,
   output logic [DATA_W-1:0] s3,
   output logic [DATA_W-1:0] s4,
   output logic [DATA_W-1:0] s5,
   output logic [DATA_W-1:0] s6,
   output logic [DATA_W-1:0] s7,
   output logic [DATA_W-1:0] t0,
   output logic [DATA_W-1:0] t1,
   output logic [DATA_W-1:0] t2,
   output logic [DATA_W-1:0] t3,
   output logic [DATA_W-1:0] t4,
   output logic [DATA_W-1:0] t5,
   output logic [DATA_W-1:0] t6,
   output logic [DATA_W-1:0] t7
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   wb_state_t         state, state_nx;
   logic [TW-1:0]     timer, timer_nx;
   logic [3:0]        pend_idx, pend_nx;
   logic [DATA_W-1:0] regs [16];
   logic [DATA_W-1:0] view [16];

   logic [4:0]        dest_unused;
   logic [3:0]        dest_idx;
   logic              dest_ok;
   logic              xfer;
   logic              we;
   logic [3:0]        widx;
   logic [DATA_W-1:0] wdata;

   wb_dest_select u_dest (
      .instruction (instruction),
      .dest        (dest_unused),
      .file_idx    (dest_idx),
      .dest_ok     (dest_ok)
   );

   assign wb_ready = (state == WB_IDLE);
   assign xfer     = wb_valid && wb_ready;

   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      pend_nx    = pend_idx;
      we         = 1'b0;
      widx       = dest_idx;
      wdata      = alu_result;
      wb_ignored = 1'b0;
      wb_timeout = 1'b0;
      unique case (state)
         WB_IDLE: begin
            if (xfer && RegW) begin
               if (!dest_ok) begin
                  wb_ignored = 1'b1;
               end else if (MemToReg) begin
                  state_nx = WB_WAIT_MEM;
                  timer_nx = '0;
                  pend_nx  = dest_idx;
               end else begin
                  we = 1'b1;
               end
            end
         end
         WB_WAIT_MEM: begin
            widx  = pend_idx;
            wdata = mem_rdata;
            // data arriving on the last allowed cycle still wins
            if (mem_rdata_valid) begin
               we       = 1'b1;
               state_nx = WB_IDLE;
            end else if (timer == TW'(MEM_TIMEOUT - 1)) begin
               wb_timeout = 1'b1;
               state_nx   = WB_IDLE;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         default: state_nx = WB_IDLE;
      endcase
      if (rst) begin
         we         = 1'b0;
         wb_ignored = 1'b0;
         wb_timeout = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WB_IDLE;
         timer    <= '0;
         pend_idx <= '0;
         for (int i = 0; i < 16; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else begin
         state    <= state_nx;
         timer    <= timer_nx;
         pend_idx <= pend_nx;
         if (we) begin
            regs[widx] <= wdata;
         end
      end
   end

   for (genvar g = 0; g < 16; g++) begin : g_view
`ifdef WB_BYPASS_EN
      assign view[g] = (we && widx == 4'(g)) ? wdata : regs[g];
`else
      assign view[g] = regs[g];
`endif
   end

   assign t0 = view[0];
   assign t1 = view[1];
   assign t2 = view[2];
   assign t3 = view[3];
   assign t4 = view[4];
   assign t5 = view[5];
   assign t6 = view[6];
   assign t7 = view[7];
   assign s0 = view[8];
   assign s1 = view[9];
   assign s2 = view[10];
   assign s3 = view[11];
   assign s4 = view[12];
   assign s5 = view[13];
   assign s6 = view[14];
   assign s7 = view[15];

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: ALU/load writes, timeout, drops,
// reset during a load and same-cycle visibility with/without WB_BYPASS_EN.
module tb_register_writeback;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] instruction;
   logic [31:0] alu_result;
   logic        RegW;
   logic        MemToReg;
   logic [31:0] mem_rdata;
   logic        mem_rdata_valid;
   logic        wb_ignored;
   logic        wb_timeout;
   logic [31:0] s0, s1, s2, s3, s4, s5, s6, s7;
   logic [31:0] t0, t1, t2, t3, t4, t5, t6, t7;

   logic [31:0] r   [16];
   logic [31:0] exp_r [16];
   int          checks;
   int          errors;

   register_writeback dut (
      .clk             (clk),
      .rst             (rst),
      .wb_valid        (wb_valid),
      .wb_ready        (wb_ready),
      .instruction     (instruction),
      .alu_result      (alu_result),
      .RegW            (RegW),
      .MemToReg        (MemToReg),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid),
      .wb_ignored      (wb_ignored),
      .wb_timeout      (wb_timeout),
      .s0 (s0), .s1 (s1), .s2 (s2), .s3 (s3),
      .s4 (s4), .s5 (s5), .s6 (s6), .s7 (s7),
      .t0 (t0), .t1 (t1), .t2 (t2), .t3 (t3),
      .t4 (t4), .t5 (t5), .t6 (t6), .t7 (t7)
   );

   assign r[0]  = t0;
   assign r[1]  = t1;
   assign r[2]  = t2;
   assign r[3]  = t3;
   assign r[4]  = t4;
   assign r[5]  = t5;
   assign r[6]  = t6;
   assign r[7]  = t7;
   assign r[8]  = s0;
   assign r[9]  = s1;
   assign r[10] = s2;
   assign r[11] = s3;
   assign r[12] = s4;
   assign r[13] = s5;
   assign r[14] = s6;
   assign r[15] = s7;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // rt field holds an invalid number so a wrong field choice gets dropped
   function automatic logic [31:0] rtype(input logic [4:0] rd);
      return {6'd0, 5'd1, 5'd30, rd, 11'd0};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op,
                                         input logic [4:0] rt);
      return {op, 5'd7, rt, 5'd3, 11'd0};
   endfunction

   task automatic idle_inputs();
      wb_valid        = 1'b0;
      instruction     = 32'd0;
      alu_result      = 32'd0;
      RegW            = 1'b0;
      MemToReg        = 1'b0;
      mem_rdata       = 32'd0;
      mem_rdata_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         exp_r[i] = 32'd0;
         checks++;
         if (r[i] !== 32'd0) begin
            errors++;
            $display("FAIL reset reg[%0d] got %h want 0", i, r[i]);
         end
      end
      checks++;
      if ({wb_ready, wb_ignored, wb_timeout} !== 3'b100) begin
         errors++;
         $display("FAIL reset flags got %b want 100",
                  {wb_ready, wb_ignored, wb_timeout});
      end
   endtask

   task automatic test_alu_write();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = rtype(5'd17);
      alu_result  = 32'h1234;
      RegW        = 1'b1;
      #1;
      checks++;
`ifdef WB_BYPASS_EN
      if (s1 !== 32'h1234) begin
`else
      if (s1 !== 32'h0) begin
`endif
         errors++;
         $display("FAIL alu_same_cycle s1 got %h", s1);
      end
      @(negedge clk);
      idle_inputs();
      exp_r[9] = 32'h1234;
      #1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (r[i] !== exp_r[i]) begin
            errors++;
            $display("FAIL alu_write reg[%0d] got %h want %h",
                     i, r[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_load();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = itype(6'h23, 5'd9);
      alu_result  = 32'hDEAD;
      RegW        = 1'b1;
      MemToReg    = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 3) begin
            mem_rdata       = 32'hCAFE;
            mem_rdata_valid = 1'b1;
         end
         #1;
         checks++;
         if (wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_wait ready k=%0d got %b want 0", k, wb_ready);
         end
      end
      @(negedge clk);
      idle_inputs();
      exp_r[1] = 32'hCAFE;
      #1;
      checks++;
      if (wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_done ready got %b want 1", wb_ready);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (r[i] !== exp_r[i]) begin
            errors++;
            $display("FAIL load reg[%0d] got %h want %h", i, r[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = itype(6'h23, 5'd10);
      RegW        = 1'b1;
      MemToReg    = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         checks++;
         if (wb_timeout !== (k == 15) || wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait k=%0d to=%b rdy=%b want to=%b rdy=0",
                     k, wb_timeout, wb_ready, (k == 15));
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (wb_ready !== 1'b1 || wb_timeout !== 1'b0 || t2 !== exp_r[2]) begin
         errors++;
         $display("FAIL timeout_after rdy=%b to=%b t2=%h want 1 0 %h",
                  wb_ready, wb_timeout, t2, exp_r[2]);
      end
   endtask

   task automatic test_data_wins();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = itype(6'h23, 5'd11);
      RegW        = 1'b1;
      MemToReg    = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 15) begin
            mem_rdata       = 32'h5A5A;
            mem_rdata_valid = 1'b1;
         end
      end
      #1;
      checks++;
      if (wb_timeout !== 1'b0) begin
         errors++;
         $display("FAIL data_wins timeout got %b want 0", wb_timeout);
      end
      @(negedge clk);
      idle_inputs();
      exp_r[3] = 32'h5A5A;
      #1;
      checks++;
      if (t3 !== 32'h5A5A || wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL data_wins t3=%h rdy=%b want 00005a5a 1", t3, wb_ready);
      end
   endtask

   task automatic test_ignored();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = rtype(5'd2);
      alu_result  = 32'hBAD;
      RegW        = 1'b1;
      #1;
      checks++;
      if (wb_ignored !== 1'b1) begin
         errors++;
         $display("FAIL ignored_rtype got %b want 1", wb_ignored);
      end
      @(negedge clk);
      instruction = itype(6'h23, 5'd24);
      MemToReg    = 1'b1;
      #1;
      checks++;
      if (wb_ignored !== 1'b1) begin
         errors++;
         $display("FAIL ignored_load got %b want 1", wb_ignored);
      end
      @(negedge clk);
      instruction = rtype(5'd12);
      MemToReg    = 1'b0;
      RegW        = 1'b0;
      #1;
      checks++;
      if (wb_ignored !== 1'b0) begin
         errors++;
         $display("FAIL ignored_regw0 got %b want 0", wb_ignored);
      end
      @(negedge clk);
      idle_inputs();
      mem_rdata       = 32'hFFFF;
      mem_rdata_valid = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (wb_ready !== 1'b1 || wb_ignored !== 1'b0) begin
         errors++;
         $display("FAIL ignored_after rdy=%b ign=%b want 1 0",
                  wb_ready, wb_ignored);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (r[i] !== exp_r[i]) begin
            errors++;
            $display("FAIL ignored reg[%0d] got %h want %h",
                     i, r[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = rtype(5'd13);
      alu_result  = 32'h1;
      RegW        = 1'b1;
      @(negedge clk);
      alu_result  = 32'h2;
      #1;
      checks++;
`ifdef WB_BYPASS_EN
      if (t5 !== 32'h2) begin
`else
      if (t5 !== 32'h1) begin
`endif
         errors++;
         $display("FAIL b2b_mid t5 got %h", t5);
      end
      @(negedge clk);
      idle_inputs();
      exp_r[5] = 32'h2;
      #1;
      checks++;
      if (t5 !== 32'h2) begin
         errors++;
         $display("FAIL b2b_last t5 got %h want 00000002", t5);
      end
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = itype(6'h23, 5'd12);
      RegW        = 1'b1;
      MemToReg    = 1'b1;
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst             = 1'b0;
      mem_rdata       = 32'hBEEF;
      mem_rdata_valid = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_wait ready got %b want 1", wb_ready);
      end
      for (int i = 0; i < 16; i++) begin
         exp_r[i] = 32'd0;
         checks++;
         if (r[i] !== 32'd0) begin
            errors++;
            $display("FAIL rst_wait reg[%0d] got %h want 0", i, r[i]);
         end
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wb_valid    = 1'b1;
      instruction = rtype(5'd20);
      alu_result  = 32'd7;
      RegW        = 1'b1;
      #1;
      checks++;
`ifdef WB_BYPASS_EN
      if (s4 !== 32'd7) begin
`else
      if (s4 !== 32'd0) begin
`endif
         errors++;
         $display("FAIL bypass_accept s4 got %h", s4);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (s4 !== 32'd7) begin
         errors++;
         $display("FAIL bypass_next s4 got %h want 00000007", s4);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_alu_write();
      test_load();
      test_timeout();
      test_data_wins();
      test_ignored();
      test_back_to_back();
      test_reset_in_wait();
      test_bypass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
